hyperbus_target: RTL and testbench

HyperBus target (device-side) responder that answers the transactions issued by the HyperRAM host controller: it decodes the 48-bit command/address, applies initial latency, returns read data with an RWDS strobe, and accepts write data into an internal word memory or configuration registers. It sits on the far side of the DQ/RWDS/CS# wires in the loopback and FPGA-internal test build, replacing the external HyperRAM so controller behaviour can be checked without a device.

---
 rtl/hyperbus_target.sv | 212 +++++++++++++++++++++
 tb/tb_hyperbus_target.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hyperbus_target.sv
// HyperBus target responder: decodes the 48-bit CA, applies initial latency,
// and serves reads/writes from a 2^ADDR_W x 16 word memory or the ID/CR registers.
// Optional: HYPERBUS_TGT_DBL_LAT_EN forces double latency and flags it on RWDS.
module hyperbus_target #(
  parameter int          ADDR_W  = 10,
  parameter int          LATENCY = 6,
  parameter logic [15:0] ID0_VAL = 16'h0c81,
  parameter logic [15:0] ID1_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csn,
  input  logic        ck_en,
  input  logic [15:0] dq_in,
  input  logic        rwds_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        rwds_out,
  output logic        rwds_oe
);

`ifdef HYPERBUS_TGT_DBL_LAT_EN
  localparam int   LEFF    = 2 * LATENCY;
  localparam logic DBL_BIT = 1'b1;
`else
  localparam int   LEFF    = LATENCY;
  localparam logic DBL_BIT = 1'b0;
`endif
  localparam logic [7:0] LAT_LAST = 8'(LEFF - 1);

  typedef enum logic [2:0] {IDLE, CA, LAT, RDATA, WDATA, REGW, WAITCS} state_t;

  state_t              state_q, state_d;
  logic [31:0]         ca_hi_q, ca_hi_d;     // CA[47:16]
  logic                ca_cnt_q, ca_cnt_d;
  logic [7:0]          lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d, reg_q, reg_d, lin_q, lin_d;
  logic [1:0]          sel_q, sel_d;
  logic [15:0]         cr0_q, cr0_d, cr1_q, cr1_d;
  logic                dq_oe_q, dq_oe_d, rwds_out_q, rwds_out_d, rwds_oe_q, rwds_oe_d;
  logic [15:0]         dq_out_q;

  logic [15:0]         mem [2**ADDR_W];
  logic                dout_ld, dout_mem, mem_we;
  logic [ADDR_W-1:0]   dout_raddr, addr_nxt, ca_addr;
  logic [47:0]         ca_full;
  logic [31:0]         ca_addr_w;
  logic [15:0]         reg_val;
  logic                unused_bits;

  assign ca_full     = {ca_hi_q, dq_in};
  assign ca_addr_w   = {ca_full[44:16], ca_full[2:0]};
  assign ca_addr     = ca_addr_w[ADDR_W-1:0];
  assign unused_bits = ^{ca_full[47:45], ca_full[15:3], ca_addr_w};

  // Wrapped bursts stay inside the aligned 16-word group; linear rolls over the array
  assign addr_nxt = lin_q ? addr_q + 1'b1 : {addr_q[ADDR_W-1:4], addr_q[3:0] + 4'd1};

  // Register read mux; ID registers are constants
  always_comb begin
    case (sel_q)
      2'b00:   reg_val = ID0_VAL;
      2'b01:   reg_val = ID1_VAL;
      2'b10:   reg_val = cr0_q;
      default: reg_val = cr1_q;
    endcase
  end

  // Next-state, datapath and output control; nothing moves unless a beat occurs
  always_comb begin
    state_d    = state_q;
    ca_hi_d    = ca_hi_q;
    ca_cnt_d   = ca_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    reg_d      = reg_q;
    lin_d      = lin_q;
    sel_d      = sel_q;
    cr0_d      = cr0_q;
    cr1_d      = cr1_q;
    dq_oe_d    = dq_oe_q;
    rwds_out_d = rwds_out_q;
    rwds_oe_d  = rwds_oe_q;
    dout_ld    = 1'b0;
    dout_mem   = 1'b0;
    dout_raddr = addr_q;
    mem_we     = 1'b0;
    if (csn) begin
      state_d    = IDLE;
      dq_oe_d    = 1'b0;
      rwds_oe_d  = 1'b0;
      rwds_out_d = 1'b0;
    end else if (ck_en) begin
      case (state_q)
        IDLE: begin
          ca_hi_d[31:16] = dq_in;
          ca_cnt_d       = 1'b0;
          state_d        = CA;
          rwds_oe_d      = 1'b1;
          rwds_out_d     = DBL_BIT;
        end
        CA: begin
          if (!ca_cnt_q) begin
            ca_hi_d[15:0] = dq_in;
            ca_cnt_d      = 1'b1;
          end else begin
            rd_d      = ca_full[47];
            reg_d     = ca_full[46];
            lin_d     = ca_full[45];
            addr_d    = ca_addr;
            sel_d     = {ca_full[24], ca_full[0]};
            lat_cnt_d = '0;
            if (!ca_full[47] && ca_full[46]) begin
              state_d    = REGW;
              rwds_oe_d  = 1'b0;
              rwds_out_d = 1'b0;
            end else begin
              state_d = LAT;
            end
          end
        end
        LAT: begin
          lat_cnt_d = lat_cnt_q + 8'd1;
          if (lat_cnt_q == LAT_LAST) begin
            if (rd_q) begin
              state_d    = RDATA;
              dq_oe_d    = 1'b1;
              rwds_out_d = 1'b1;
              dout_ld    = 1'b1;
              dout_mem   = !reg_q;
            end else begin
              state_d    = WDATA;
              rwds_oe_d  = 1'b0;
              rwds_out_d = 1'b0;
            end
          end
        end
        RDATA: begin
          addr_d     = addr_nxt;
          dout_ld    = 1'b1;
          dout_mem   = !reg_q;
          dout_raddr = addr_nxt;
        end
        WDATA: begin
          mem_we = !rwds_in;
          addr_d = addr_nxt;
        end
        REGW: begin
          if (sel_q == 2'b10) cr0_d = dq_in;
          if (sel_q == 2'b11) cr1_d = dq_in;
          state_d = WAITCS;
        end
        WAITCS:  state_d = WAITCS;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control/config registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ca_hi_q    <= '0;
      ca_cnt_q   <= 1'b0;
      lat_cnt_q  <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      reg_q      <= 1'b0;
      lin_q      <= 1'b0;
      sel_q      <= '0;
      cr0_q      <= 16'h8f1f;
      cr1_q      <= 16'h0002;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 1'b0;
      rwds_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ca_hi_q    <= ca_hi_d;
      ca_cnt_q   <= ca_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      reg_q      <= reg_d;
      lin_q      <= lin_d;
      sel_q      <= sel_d;
      cr0_q      <= cr0_d;
      cr1_q      <= cr1_d;
      dq_oe_q    <= dq_oe_d;
      rwds_out_q <= rwds_out_d;
      rwds_oe_q  <= rwds_oe_d;
    end
  end

  // Memory write port (contents deliberately not reset)
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= dq_in;
  end

  // Registered read port; fetching the next address each beat keeps bursts gapless
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          dq_out_q <= '0;
    else if (dout_ld) dq_out_q <= dout_mem ? mem[dout_raddr] : reg_val;
  end

  assign dq_out   = dq_out_q;
  assign dq_oe    = dq_oe_q;
  assign rwds_out = rwds_out_q;
  assign rwds_oe  = rwds_oe_q;

endmodule

// File: tb/tb_hyperbus_target.sv
// Directed bench for hyperbus_target: register/memory reads and writes, burst
// wrap modes, write masking, csn abort, mid-burst reset, latency boundary.
module tb_hyperbus_target;
`ifdef HYPERBUS_TGT_DBL_LAT_EN
  localparam int   LEFF = 12;
  localparam logic DBL  = 1'b1;
`else
  localparam int   LEFF = 6;
  localparam logic DBL  = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, csn = 1'b1, ck_en = 1'b0, rwds_in = 1'b0;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out;
  logic        dq_oe, rwds_out, rwds_oe;
  int          n_chk = 0, n_err = 0;
  logic [15:0] wbuf [16];
  logic [15:0] rbuf [4];

  hyperbus_target dut (
    .clk(clk), .rst(rst), .csn(csn), .ck_en(ck_en), .dq_in(dq_in), .rwds_in(rwds_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .rwds_out(rwds_out), .rwds_oe(rwds_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Present one cycle of host signals, then return 1 time unit after the edge
  task automatic drive(input logic c, input logic e, input logic [15:0] d, input logic m);
    csn = c; ck_en = e; dq_in = d; rwds_in = m;
    @(posedge clk); #1;
  endtask

  task automatic send_ca(input logic [47:0] ca);
    drive(1'b0, 1'b1, ca[47:32], 1'b0);
    chk("ca_rwds_oe", 16'(rwds_oe), 16'd1);
    chk("ca_rwds_lat", 16'(rwds_out), 16'(DBL));
    drive(1'b0, 1'b1, ca[31:16], 1'b0);
    drive(1'b0, 1'b1, ca[15:0], 1'b0);
  endtask

  task automatic rd_burst(input string tag, input logic [47:0] ca, input int n, input bit stall);
    send_ca(ca);
    for (int i = 0; i < LEFF; i++) begin
      if (i == LEFF - 1) chk({tag, "_early_oe"}, 16'(dq_oe), 16'd0);
      drive(1'b0, 1'b1, 16'h0, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d", tag, i), dq_out, rbuf[i]);
      if (i == 0) begin
        chk({tag, "_dq_oe"}, 16'(dq_oe), 16'd1);
        chk({tag, "_rwds"}, 16'({rwds_oe, rwds_out}), 16'd3);
      end
      if (stall && i == 0) begin
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk({tag, "_hold"}, dq_out, rbuf[0]);
      end
      drive(1'b0, 1'b1, 16'h0, 1'b0);
    end
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    chk({tag, "_release"}, 16'({dq_oe, rwds_oe}), 16'd0);
  endtask

  task automatic wr_burst(input logic [47:0] ca, input int n, input int mask_idx);
    send_ca(ca);
    repeat (LEFF) drive(1'b0, 1'b1, 16'h0, 1'b0);
    chk("wr_rwds_oe", 16'(rwds_oe), 16'd0);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, wbuf[i], i == mask_idx);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic reg_wr(input logic [47:0] ca, input logic [15:0] d);
    send_ca(ca);
    drive(1'b0, 1'b1, d, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dq_out", dq_out, 16'h0);
    chk("rst_oe", 16'({dq_oe, rwds_oe, rwds_out}), 16'd0);
    rst = 1'b0;
    repeat (2) drive(1'b1, 1'b0, 16'h0, 1'b0);

    // ID / CR reads
    rbuf[0] = 16'h0000; rbuf[1] = 16'h0000;
    rd_burst("id1", 48'hc000_0000_0001, 2, 1'b0);
    rbuf[0] = 16'h0c81; rbuf[1] = 16'h0c81;
    rd_burst("id0", 48'hc000_0000_0000, 2, 1'b0);
    rbuf[0] = 16'h8f1f;
    rd_burst("cr0_rst", 48'hc000_0100_0000, 1, 1'b0);
    rbuf[0] = 16'h0002;
    rd_burst("cr1_rst", 48'hc000_0100_0001, 1, 1'b0);

    // Register writes: CR0 takes the value, ID0 ignores it
    reg_wr(48'h6000_0100_0000, 16'h8f17);
    rbuf[0] = 16'h8f17;
    rd_burst("cr0_wr", 48'hc000_0100_0000, 1, 1'b0);
    reg_wr(48'h6000_0000_0000, 16'h1234);
    rbuf[0] = 16'h0c81;
    rd_burst("id0_wr", 48'hc000_0000_0000, 1, 1'b0);

    // Linear write across the top of memory, third word masked
    wbuf[0] = 16'habcd;
    wr_burst(48'h2000_0000_0000, 1, -1);
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
    wr_burst(48'h2000_007f_0006, 4, 2);
    rbuf[0] = 16'h1111; rbuf[1] = 16'h2222; rbuf[2] = 16'habcd; rbuf[3] = 16'h4444;
    rd_burst("lin", 48'ha000_007f_0006, 4, 1'b0);

    // Wrapped read within the 0x20 group, with a ck_en stall
    for (int i = 0; i < 16; i++) wbuf[i] = 16'h0020 + 16'(i);
    wr_burst(48'h2000_0004_0000, 16, -1);
    rbuf[0] = 16'h002e; rbuf[1] = 16'h002f; rbuf[2] = 16'h0020; rbuf[3] = 16'h0021;
    rd_burst("wrap", 48'h8000_0005_0006, 4, 1'b1);

    // csn abort after two CA words, then a clean transaction
    drive(1'b0, 1'b1, 16'hc000, 1'b0);
    drive(1'b0, 1'b1, 16'h0100, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    chk("abort_oe", 16'({dq_oe, rwds_oe, rwds_out}), 16'd0);
    rbuf[0] = 16'h0002;
    rd_burst("after_abort", 48'hc000_0100_0001, 1, 1'b0);

    // Asynchronous reset in the middle of a data burst
    send_ca(48'ha000_007f_0006);
    repeat (LEFF + 1) drive(1'b0, 1'b1, 16'h0, 1'b0);
    chk("pre_rst_oe", 16'(dq_oe), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dq_out", dq_out, 16'h0);
    chk("mid_rst_oe", 16'({dq_oe, rwds_oe, rwds_out}), 16'd0);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    rbuf[0] = 16'h8f1f;
    rd_burst("cr0_after_rst", 48'hc000_0100_0000, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
